// File: rtl/ooo_read_queue_pkg.sv
// ============================================================================
// ooo_read_queue_pkg : shared defaults, picker result type, count-width helper
// Rev 1.0
// ============================================================================
`default_nettype none

package ooo_read_queue_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_TAG_W  = 4;
  localparam int DEF_DEPTH  = 8;

  // Queue depth is bounded at 16, so a 4-bit index always covers every entry.
  localparam int MAX_DEPTH = 16;
  localparam int PIDX_W    = 4;

  typedef struct packed {
    logic              valid;
    logic [PIDX_W-1:0] idx;
  } pick_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ooo_read_queue_if.sv
// ============================================================================
// ooo_read_queue_if : request, snoop, RAM read and response bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface ooo_read_queue_if
  import ooo_read_queue_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int CNT_W  = cnt_width(DEF_DEPTH)
);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [TAG_W-1:0]  req_tag;
  logic              snoop_we;
  logic [ADDR_W-1:0] snoop_waddr;
  logic [ADDR_W-1:0] ram_raddr0;
  logic [DATA_W-1:0] ram_rdata0;
  logic [ADDR_W-1:0] ram_raddr1;
  logic [DATA_W-1:0] ram_rdata1;
  logic              rsp0_valid;
  logic [TAG_W-1:0]  rsp0_tag;
  logic [DATA_W-1:0] rsp0_data;
  logic              rsp1_valid;
  logic [TAG_W-1:0]  rsp1_tag;
  logic [DATA_W-1:0] rsp1_data;
  logic [CNT_W-1:0]  count;

  // Environment side: front end, write-port snoop and RAM read data.
  modport master (
    output req_valid, req_addr, req_tag, snoop_we, snoop_waddr, ram_rdata0, ram_rdata1,
    input  req_ready, ram_raddr0, ram_raddr1,
    input  rsp0_valid, rsp0_tag, rsp0_data, rsp1_valid, rsp1_tag, rsp1_data, count
  );

  modport slave (
    input  req_valid, req_addr, req_tag, snoop_we, snoop_waddr, ram_rdata0, ram_rdata1,
    output req_ready, ram_raddr0, ram_raddr1,
    output rsp0_valid, rsp0_tag, rsp0_data, rsp1_valid, rsp1_tag, rsp1_data, count
  );

endinterface

`default_nettype wire

// File: rtl/ooo_read_queue_pick2.sv
// ============================================================================
// ooo_read_queue_pick2 : finds the two lowest-index (oldest) eligible entries
// Rev 1.0
// ============================================================================
`default_nettype none

module ooo_read_queue_pick2
  import ooo_read_queue_pkg::*;
#(
  parameter int DEPTH        = DEF_DEPTH,
  parameter int NUM_RD_PORTS = 2
) (
  input  logic [DEPTH-1:0] elig_i,
  output pick_t            pick0_o,
  output pick_t            pick1_o
);

  pick_t p0;
  pick_t p1;

  always_comb begin
    p0 = '0;
    p1 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (elig_i[i]) begin
        if (!p0.valid) begin
          p0.valid = 1'b1;
          p0.idx   = PIDX_W'(i);
        end else if (!p1.valid && (NUM_RD_PORTS == 2)) begin
          p1.valid = 1'b1;
          p1.idx   = PIDX_W'(i);
        end
      end
    end
  end

  assign pick0_o = p0;
  assign pick1_o = p1;

endmodule

`default_nettype wire

// File: rtl/ooo_read_queue.sv
// ============================================================================
// ooo_read_queue : compacting tagged read queue, issues the two oldest
//                  non-conflicting reads per cycle, responses in completion order
// Rev 1.0
// ============================================================================
`default_nettype none

module ooo_read_queue
  import ooo_read_queue_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int TAG_W        = DEF_TAG_W,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int NUM_RD_PORTS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  ooo_read_queue_if.slave  bus
);

  localparam int CNT_W = cnt_width(DEPTH);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [TAG_W-1:0]  tag;
  } rd_entry_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } rsp_t;

  rd_entry_t        ent_q [DEPTH];
  rd_entry_t        ent_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_q;
  rsp_t             rsp0_q, rsp0_d;
  rsp_t             rsp1_q, rsp1_d;

  logic [DEPTH-1:0] elig;
  logic [DEPTH-1:0] issued;
  pick_t            pick0, pick1;
  rd_entry_t        sel0, sel1;
  logic [CNT_W-1:0] kept;
  logic             accept;

  // An entry whose address is written this cycle must wait, or it would return stale data.
  always_comb begin
    elig = '0;
    for (int i = 0; i < DEPTH; i++) begin
      elig[i] = ent_q[i].valid && !(bus.snoop_we && (bus.snoop_waddr == ent_q[i].addr));
    end
  end

  ooo_read_queue_pick2 #(
    .DEPTH        (DEPTH),
    .NUM_RD_PORTS (NUM_RD_PORTS)
  ) u_pick2 (
    .elig_i  (elig),
    .pick0_o (pick0),
    .pick1_o (pick1)
  );

  always_comb begin
    sel0   = '0;
    sel1   = '0;
    issued = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (pick0.valid && (pick0.idx == PIDX_W'(i))) begin
        sel0      = ent_q[i];
        issued[i] = 1'b1;
      end
      if (pick1.valid && (pick1.idx == PIDX_W'(i))) begin
        sel1      = ent_q[i];
        issued[i] = 1'b1;
      end
    end
  end

  assign accept = bus.req_valid && ready_q;

  // Survivors slide down in age order; the new request lands just behind them.
  always_comb begin
    kept = '0;
    for (int j = 0; j < DEPTH; j++) begin
      ent_d[j] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid && !issued[i]) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (kept == CNT_W'(j)) begin
            ent_d[j] = ent_q[i];
          end
        end
        kept = kept + CNT_W'(1);
      end
    end
    if (accept) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (kept == CNT_W'(j)) begin
          ent_d[j].valid = 1'b1;
          ent_d[j].addr  = bus.req_addr;
          ent_d[j].tag   = bus.req_tag;
        end
      end
    end
    count_d = kept + CNT_W'(accept);
  end

  always_comb begin
    rsp0_d.valid = pick0.valid;
    rsp0_d.tag   = sel0.tag;
    rsp0_d.data  = pick0.valid ? bus.ram_rdata0 : '0;
    rsp1_d.valid = pick1.valid;
    rsp1_d.tag   = sel1.tag;
    rsp1_d.data  = pick1.valid ? bus.ram_rdata1 : '0;
  end

  // Ready is registered from the next count so that it reads low while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      count_q <= '0;
      ready_q <= 1'b0;
      rsp0_q  <= '0;
      rsp1_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
      count_q <= count_d;
      ready_q <= (count_d < CNT_W'(DEPTH));
      rsp0_q  <= rsp0_d;
      rsp1_q  <= rsp1_d;
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.count      = count_q;
  assign bus.ram_raddr0 = sel0.addr;
  assign bus.ram_raddr1 = sel1.addr;
  assign bus.rsp0_valid = rsp0_q.valid;
  assign bus.rsp0_tag   = rsp0_q.tag;
  assign bus.rsp0_data  = rsp0_q.data;
  assign bus.rsp1_valid = rsp1_q.valid;
  assign bus.rsp1_tag   = rsp1_q.tag;
  assign bus.rsp1_data  = rsp1_q.data;

endmodule

`default_nettype wire
